// File: rtl/knight_pkg.sv
// Shared types and constants for the knight remote command link.
//   asm_state_t : command assembly FSM states (high byte, then low byte)
//   tx_state_t  : response transmitter states
//   rx_state_t  : frame receiver states
//   ACK_BYTE    : response byte the robot returns to acknowledge a command
package knight_pkg;

   typedef enum logic {WAIT_HIGH, WAIT_LOW} asm_state_t;
   typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
   typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;

   localparam logic [7:0] ACK_BYTE = 8'hA5;

endpackage

// File: rtl/knight_uart_phy.sv
// 8N1 serial PHY: RX synchronizer and sampler, TX shifter.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   rx         : raw serial input (idle high, asynchronous to clk)
//   tx         : serial output (idle high)
//   rx_active  : a frame is being received (including the start-detect cycle)
//   rx_done    : one-cycle strobe in the stop-sample cycle, good stop bit
//   rx_err     : one-cycle strobe in the stop-sample cycle, stop bit read 0
//   rx_byte    : received data byte, valid while rx_done is high
//   tx_data    : byte to transmit, latched when tx_start is high
//   tx_req     : transmit request; ignored while a frame is shifting out
//   tx_start   : request accepted this cycle
//   tx_done    : strobe in the last cycle of the stop bit
module knight_uart_phy
   import knight_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   output logic       rx_active,
   output logic       rx_done,
   output logic       rx_err,
   output logic [7:0] rx_byte,
   input  logic [7:0] tx_data,
   input  logic       tx_req,
   output logic       tx_start,
   output logic       tx_done
);

   localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

   logic             rx_p0, rx_p1, rx_p2;
   rx_state_t        rx_state, rx_next;
   logic [CNT_W-1:0] rx_cnt;
   logic [3:0]       rx_idx;
   logic             rx_fall, rx_sample;

   tx_state_t        tx_state, tx_next;
   logic [CNT_W-1:0] tx_cnt;
   logic [3:0]       tx_idx;
   logic [9:0]       tx_sh;

   // synchronizer stages; rx_p2 only remembers the previous synchronized level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
         rx_p2 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
      end
   end

   // edge rather than level start detect, so a line still low after a bad
   // stop bit cannot retrigger a frame
   assign rx_fall   = rx_p2 & ~rx_p1;
   assign rx_sample = (rx_state == RX_BUSY) && (rx_cnt == '0);
   assign rx_active = (rx_state == RX_BUSY) || rx_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_state <= RX_IDLE;
      else     rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      rx_done = 1'b0;
      rx_err  = 1'b0;
      case (rx_state)
         RX_IDLE: if (rx_fall) rx_next = RX_BUSY;
         RX_BUSY: begin
            if (rx_sample) begin
               if (rx_idx == 4'd0 && rx_p1) begin
                  rx_next = RX_IDLE;          // start glitch
               end else if (rx_idx == 4'd9) begin
                  rx_next = RX_IDLE;
                  rx_done = rx_p1;
                  rx_err  = ~rx_p1;
               end
            end
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   // first sample lands mid start bit, then one sample per bit period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_cnt <= '0;
         rx_idx <= '0;
      end else if (rx_state == RX_IDLE) begin
         rx_cnt <= CNT_W'(BAUD_DIV / 2 - 1);
         rx_idx <= '0;
      end else if (rx_cnt == '0) begin
         rx_cnt <= CNT_W'(BAUD_DIV - 1);
         rx_idx <= rx_idx + 4'd1;
      end else begin
         rx_cnt <= rx_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rx_sample && rx_idx != 4'd0 && rx_idx != 4'd9)
         rx_byte <= {rx_p1, rx_byte[7:1]};
   end

   assign tx_start = tx_req && (tx_state == TX_IDLE);
   assign tx_done  = (tx_state == TX_SHIFT) && (tx_cnt == '0) && (tx_idx == 4'd9);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tx_state <= TX_IDLE;
      else     tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:  if (tx_req)  tx_next = TX_SHIFT;
         TX_SHIFT: if (tx_done) tx_next = TX_IDLE;
         default:  tx_next = TX_IDLE;
      endcase
   end

   // ones are shifted in behind the frame so the line rests high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_sh  <= '1;
         tx_cnt <= '0;
         tx_idx <= '0;
      end else if (tx_start) begin
         tx_sh  <= {1'b1, tx_data, 1'b0};
         tx_cnt <= CNT_W'(BAUD_DIV - 1);
         tx_idx <= '0;
      end else if (tx_state == TX_SHIFT) begin
         if (tx_cnt == '0) begin
            tx_sh  <= {1'b1, tx_sh[9:1]};
            tx_cnt <= CNT_W'(BAUD_DIV - 1);
            tx_idx <= tx_idx + 4'd1;
         end else begin
            tx_cnt <= tx_cnt - CNT_W'(1);
         end
      end
   end

   assign tx = tx_sh[0];

endmodule

// File: rtl/knight_cmd_rx.sv
// Robot-side endpoint of the two-byte remote command link.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   RX, TX      : 8N1 serial in / out, both idle high
//   cmd         : last complete command {high byte, low byte}
//   cmd_rdy     : command available; cleared by clr_cmd_rdy or a new high byte
//   clr_cmd_rdy : consumer acknowledge
//   resp        : response byte, latched on send_resp
//   send_resp   : start a response frame (ignored while one is in flight)
//   resp_sent   : response frame fully shifted out
//   frame_err   : one-cycle pulse on a bad stop bit
module knight_cmd_rx
   import knight_pkg::*;
#(
   parameter int BAUD_DIV     = 2604,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic        frame_err
);

   localparam int TMO_CYC = TIMEOUT_BITS * BAUD_DIV;
   localparam int TMO_W   = $clog2(TMO_CYC + 1);

   logic             rx_active, rx_done, rx_err, tx_start, tx_done;
   logic [7:0]       rx_byte;
   logic [7:0]       hi_byte;
   logic [TMO_W-1:0] tmo;
   logic             hi_done, lo_done;
   asm_state_t       asm_state, asm_next;

   knight_uart_phy #(.BAUD_DIV(BAUD_DIV)) u_phy (
      .clk       (clk),
      .rst       (rst),
      .rx        (RX),
      .tx        (TX),
      .rx_active (rx_active),
      .rx_done   (rx_done),
      .rx_err    (rx_err),
      .rx_byte   (rx_byte),
      .tx_data   (resp),
      .tx_req    (send_resp),
      .tx_start  (tx_start),
      .tx_done   (tx_done)
   );

   assign hi_done = rx_done && (asm_state == WAIT_HIGH);
   assign lo_done = rx_done && (asm_state == WAIT_LOW);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) asm_state <= WAIT_HIGH;
      else     asm_state <= asm_next;
   end

   always_comb begin
      asm_next = asm_state;
      if (rx_err) begin
         asm_next = WAIT_HIGH;
      end else begin
         case (asm_state)
            WAIT_HIGH: if (rx_done) asm_next = WAIT_LOW;
            WAIT_LOW: begin
               if (rx_done)                        asm_next = WAIT_HIGH;
               else if (!rx_active && tmo == '0)   asm_next = WAIT_HIGH;
            end
            default: asm_next = WAIT_HIGH;
         endcase
      end
   end

   // timeout only runs while the line is idle between the two bytes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo <= '0;
      end else if (hi_done) begin
         tmo <= TMO_W'(TMO_CYC);
      end else if (asm_state == WAIT_LOW && !rx_active && tmo != '0) begin
         tmo <= tmo - TMO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (hi_done) hi_byte <= rx_byte;
   end

   // set takes priority over any clear in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd     <= '0;
         cmd_rdy <= 1'b0;
      end else if (lo_done) begin
         cmd     <= {hi_byte, rx_byte};
         cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy || hi_done) begin
         cmd_rdy <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
         resp_sent <= 1'b0;
      end else begin
         frame_err <= rx_err;
         if (tx_start)     resp_sent <= 1'b0;
         else if (tx_done) resp_sent <= 1'b1;
      end
   end

endmodule

// File: tb/tb_knight_cmd_rx.sv
// Self-checking bench for knight_cmd_rx with BAUD_DIV=16, TIMEOUT_BITS=4.
// A byte-level model pairs received frames into commands from the link rules
// (bad stop drops a pending high byte, long idle gap drops it too).
module tb_knight_cmd_rx;

   localparam int BD   = 16;
   localparam int TMOB = 4;

   logic        clk = 1'b0;
   logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, frame_err;
   logic [15:0] cmd;
   logic [7:0]  resp;

   int n_cmp = 0;
   int n_bad = 0;
   int ferr_seen = 0;

   // reference model state
   logic [15:0] exp_cmd = 16'h0;
   logic        exp_rdy = 1'b0;
   int          exp_ferr = 0;
   logic [7:0]  pend_hi = 8'h0;
   bit          have_hi = 0;

   knight_cmd_rx #(.BAUD_DIV(BD), .TIMEOUT_BITS(TMOB)) dut (
      .clk         (clk),
      .rst         (rst),
      .RX          (RX),
      .TX          (TX),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .resp        (resp),
      .send_resp   (send_resp),
      .resp_sent   (resp_sent),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_err === 1'b1) ferr_seen++;

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_frame(input logic [7:0] b, input logic stop, input int gap);
      if (!stop) begin
         exp_ferr++;
         have_hi = 0;
      end else if (!have_hi) begin
         pend_hi = b;
         have_hi = 1;
         exp_rdy = 1'b0;
      end else begin
         exp_cmd = {pend_hi, b};
         exp_rdy = 1'b1;
         have_hi = 0;
      end
      if (have_hi && gap > TMOB) have_hi = 0;
   endfunction

   // data, stop and trailing idle gap; start bit is already on the line
   task automatic send_body(input logic [7:0] b, input logic stop, input int gap);
      for (int i = 0; i < 8; i++) begin
         repeat (BD) @(negedge clk);
         RX = b[i];
      end
      repeat (BD) @(negedge clk);
      RX = stop;
      repeat (BD) @(negedge clk);
      RX = 1'b1;
      repeat (BD * gap) @(negedge clk);
      model_frame(b, stop, gap);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
      @(negedge clk);
      RX = 1'b0;
      send_body(b, stop, gap);
   endtask

   // expected line level for bit k of a response frame
   function automatic logic tx_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   task automatic tx_check(input logic [7:0] b, input bit poke);
      @(negedge clk);
      resp = b;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      for (int j = 0; j <= 10 * BD; j++) begin
         check("tx_line", TX, tx_bit(b, j / BD));
         check("resp_sent", resp_sent, (j == 10 * BD));
         if (poke && j == 50) begin
            resp = ~b;
            send_resp = 1'b1;
         end
         if (poke && j == 51) send_resp = 1'b0;
         if (j < 10 * BD) @(negedge clk);
      end
      resp = b;
   endtask

   initial begin
      int k;
      int f0;
      int gaps[5] = '{0, 1, 2, 6, 7};
      logic [7:0] rb;
      logic       rs;
      int         rg;

      rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", TX, 1'b1);
      check("rst_cmd", cmd, 16'h0);
      check("rst_cmd_rdy", cmd_rdy, 1'b0);
      check("rst_resp_sent", resp_sent, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // command reception with exact latency from the low byte's start edge
      send_frame(8'h3C, 1'b1, 1);
      @(negedge clk);
      RX = 1'b0;
      k = 0;
      fork
         send_body(8'h5A, 1'b1, 1);
         begin
            while (cmd_rdy !== 1'b1 && k < 400) begin
               @(posedge clk);
               #1;
               k++;
            end
         end
      join
      check("rdy_latency", k, 2 + BD / 2 + 9 * BD + 1);
      check("cmd_3c5a", cmd, 16'h3C5A);
      check("cmd_model", cmd, exp_cmd);
      @(negedge clk);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      exp_rdy = 1'b0;
      check("clr_drops_rdy", cmd_rdy, 1'b0);

      // inter-byte timeout discards the lone high byte
      send_frame(8'h12, 1'b1, 5);
      send_frame(8'h34, 1'b1, 1);
      send_frame(8'h56, 1'b1, 1);
      check("timeout_cmd", cmd, 16'h3456);
      check("timeout_model", cmd, exp_cmd);

      // bad stop bit
      f0 = ferr_seen;
      send_frame(8'hFF, 1'b0, 1);
      send_frame(8'hAB, 1'b1, 1);
      send_frame(8'hCD, 1'b1, 1);
      check("frame_err_once", ferr_seen - f0, 1);
      check("badstop_cmd", cmd, 16'hABCD);

      // response transmission, with an ignored second request mid-frame
      tx_check(knight_pkg::ACK_BYTE, 1'b1);
      tx_check(8'($urandom), 1'b0);

      // overrun, then set and clear in the same cycle
      send_frame(8'h01, 1'b1, 1);
      send_frame(8'h02, 1'b1, 1);
      check("overrun_first_cmd", cmd, 16'h0102);
      check("overrun_first_rdy", cmd_rdy, 1'b1);
      send_frame(8'h03, 1'b1, 1);
      check("hi_clears_rdy", cmd_rdy, 1'b0);
      @(negedge clk);
      RX = 1'b0;
      fork
         send_body(8'h04, 1'b1, 1);
         begin
            repeat (2 + BD / 2 + 9 * BD) @(posedge clk);
            @(negedge clk);
            check("pre_set_rdy", cmd_rdy, 1'b0);
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            check("set_wins_rdy", cmd_rdy, 1'b1);
         end
      join
      check("overrun_cmd", cmd, 16'h0304);
      check("overrun_model", cmd, exp_cmd);

      // randomized frames against the model
      for (int i = 0; i < 16; i++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 7) != 0);
         rg = gaps[$urandom_range(0, 4)];
         send_frame(rb, rs, rg);
         check("rand_cmd", cmd, exp_cmd);
         check("rand_rdy", cmd_rdy, exp_rdy);
      end
      check("frame_err_total", ferr_seen, exp_ferr);

      // reset in the middle of a response frame
      @(negedge clk);
      resp = 8'h00;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      repeat (40) @(negedge clk);
      check("mid_tx_low", TX, 1'b0);
      rst = 1'b1;
      #1;
      check("abort_tx_high", TX, 1'b1);
      check("abort_cmd", cmd, 16'h0);
      check("abort_rdy", cmd_rdy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3 * BD) @(negedge clk);
      check("post_abort_tx", TX, 1'b1);
      check("post_abort_sent", resp_sent, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
